// File: rtl/seq_divider_16x8_pkg.sv
// Shared definitions for the 16/8 sequential restoring divider: widths, counter size
// and the control-state encoding used by the top-level FSM.
package seq_divider_16x8_pkg;

  localparam int N_W   = 16;
  localparam int D_W   = 8;
  localparam int CNT_W = $clog2(N_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Quotient reported for a zero divisor.
  function automatic logic [N_W-1:0] dbz_quotient();
    return {N_W{1'b1}};
  endfunction

endpackage

// File: rtl/seq_divider_16x8_div_sub_step.sv
// One restoring step: compares the (D_W+1)-bit trial value against the divisor and
// returns the next partial remainder together with the quotient bit.
module seq_divider_16x8_div_sub_step
  import seq_divider_16x8_pkg::*;
(
  input  logic [D_W:0]   t,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] r_next,
  output logic           q_bit
);

  // Compare/subtract; the difference always fits in D_W bits when it is taken.
  always_comb begin
    q_bit = (t >= {1'b0, divisor});
    if (q_bit) begin
      r_next = D_W'(t - {1'b0, divisor});
    end else begin
      r_next = t[D_W-1:0];
    end
  end

endmodule

// File: rtl/seq_divider_16x8.sv
// Sequential restoring divider, 16-bit dividend / 8-bit divisor, one quotient bit per
// clock, with a start/done handshake and results held until the next accepted start.
module seq_divider_16x8
  import seq_divider_16x8_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           done_flag,
  output logic           busy,
  output logic           div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_W-1:0] q_q, q_d;
  logic [D_W-1:0] r_q, r_d;
  logic [D_W-1:0] dvsr_q, dvsr_d;
  logic [N_W-1:0] quot_q, quot_d;
  logic [D_W-1:0] rem_q, rem_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           dbz_q, dbz_d;

  logic [D_W:0]   step_t;
  logic [D_W-1:0] step_r;
  logic           step_bit;
  logic [N_W-1:0] q_shift;

  // The stored remainder is always below the divisor, so D_W bits hold it exactly.
  assign step_t  = {r_q, q_q[N_W-1]};
  assign q_shift = {q_q[N_W-2:0], step_bit};

  seq_divider_16x8_div_sub_step u_step (
    .t       (step_t),
    .divisor (dvsr_q),
    .r_next  (step_r),
    .q_bit   (step_bit)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          dvsr_d = divisor;
          q_d    = dividend;
          r_d    = {D_W{1'b0}};
          cnt_d  = {CNT_W{1'b0}};
          if (divisor == {D_W{1'b0}}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            quot_d  = dbz_quotient();
            rem_d   = {D_W{1'b0}};
          end else begin
            state_d = S_CALC;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        q_d   = q_shift;
        r_d   = step_r;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          quot_d  = q_shift;
          rem_d   = step_r;
        end else begin
          state_d = S_CALC;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      q_q     <= {N_W{1'b0}};
      r_q     <= {D_W{1'b0}};
      dvsr_q  <= {D_W{1'b0}};
      quot_q  <= {N_W{1'b0}};
      rem_q   <= {D_W{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign done_flag   = done_q;
  assign busy        = busy_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Self-checking bench for seq_divider_16x8: transaction-level reference model checked
// every cycle, directed literal cases, and a randomized phase.
module tb_seq_divider_16x8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        busy;
  logic        div_by_zero;

  always #5 clk = ~clk;

  seq_divider_16x8 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .done_flag   (done_flag),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: an accepted operation occupies 16 busy cycles, then results appear.
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_dbz  = 1'b0;
  logic [15:0] m_q  = 16'd0;
  logic [15:0] m_pq = 16'd0;
  logic [7:0]  m_r  = 8'd0;
  logic [7:0]  m_pr = 8'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_q    <= 16'd0;
      m_r    <= 8'd0;
    end else if (m_left == 0) begin
      if (start) begin
        if (divisor == 8'd0) begin
          m_done <= 1'b1;
          m_dbz  <= 1'b1;
          m_q    <= 16'hFFFF;
          m_r    <= 8'd0;
        end else begin
          m_left <= 16;
          m_done <= 1'b0;
          m_dbz  <= 1'b0;
          m_pq   <= dividend / {8'd0, divisor};
          m_pr   <= 8'(dividend % {8'd0, divisor});
        end
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_q    <= m_pq;
        m_r    <= m_pr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        32'(busy),        32'(m_left > 0));
      check("done_flag",   32'(done_flag),   32'(m_done));
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
      check("quotient",    32'(quotient),    32'(m_q));
      check("remainder",   32'(remainder),   32'(m_r));
    end
  end

  task automatic do_op(input string name, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input bit edbz,
                       input int elat, input int ebusy);
    int lat;
    int nbusy;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done_flag && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(elat));
    check({name, "_busy_cycles"}, 32'(nbusy), 32'(ebusy));
    check({name, "_quotient"}, 32'(quotient), 32'(eq));
    check({name, "_remainder"}, 32'(remainder), 32'(er));
    check({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    @(negedge clk);
    check({name, "_done_drop"}, 32'(done_flag), 32'd0);
  endtask

  initial begin
    int seen;
    int first;
    int second;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 8'd0;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_quotient",  32'(quotient),    32'd0);
    check("rst_remainder", 32'(remainder),   32'd0);
    check("rst_done",      32'(done_flag),   32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_dbz",       32'(div_by_zero), 32'd0);

    do_op("d1000_7",   16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 17, 16);
    do_op("dffff_ff",  16'hFFFF,  8'hFF,  16'd257,   8'd0, 1'b0, 17, 16);
    do_op("dffff_01",  16'hFFFF,  8'h01,  16'hFFFF,  8'd0, 1'b0, 17, 16);
    do_op("d5_9",      16'd5,     8'd9,   16'd0,     8'd5, 1'b0, 17, 16);
    do_op("d0_3",      16'd0,     8'd3,   16'd0,     8'd0, 1'b0, 17, 16);
    do_op("d1234_0",   16'd1234,  8'd0,   16'hFFFF,  8'd0, 1'b1, 1,  0);
    do_op("d100_10",   16'd100,   8'd10,  16'd10,    8'd0, 1'b0, 17, 16);

    // A start pulse with new operands mid-calculation must be ignored.
    start    = 1'b1;
    dividend = 16'd500;
    divisor  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    while (!done_flag && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("ignore_start_done",      32'(done_flag), 32'd1);
    check("ignore_start_quotient",  32'(quotient),  32'd166);
    check("ignore_start_remainder", 32'(remainder), 32'd2);
    @(negedge clk);

    // Reset mid-calculation aborts with cleared outputs and no done pulse.
    start    = 1'b1;
    dividend = 16'd60000;
    divisor  = 8'd250;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_quotient",  32'(quotient),    32'd0);
    check("abort_remainder", 32'(remainder),   32'd0);
    check("abort_busy",      32'(busy),        32'd0);
    check("abort_dbz",       32'(div_by_zero), 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_flag) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_op("d60000_250", 16'd60000, 8'd250, 16'd240, 8'd0, 1'b0, 17, 16);

    // Start held high: two back-to-back operations.
    start    = 1'b1;
    dividend = 16'd300;
    divisor  = 8'd7;
    @(negedge clk);
    dividend = 16'd301;
    first    = 0;
    second   = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done_flag && first == 0) begin
        first = c;
        check("b2b_first_quotient",  32'(quotient),  32'd42);
        check("b2b_first_remainder", 32'(remainder), 32'd6);
      end else if (done_flag && second == 0) begin
        second = c;
        start  = 1'b0;
        check("b2b_second_quotient",  32'(quotient),  32'd43);
        check("b2b_second_remainder", 32'(remainder), 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_first_cycle",  32'(first),  32'd17);
    check("b2b_second_cycle", 32'(second), 32'd34);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      dividend = 16'($urandom);
      if ($urandom_range(0, 4) == 0) dividend = 16'($urandom_range(0, 255));
      divisor  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      reset    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
